// File: rtl/kernel_launcher.sv
// kernel_launcher: preloads path memory, kicks the kernel, waits for its
// write port to go quiet, then dumps memory and reports a modular checksum.
module kernel_launcher #(
  parameter int WIDTH        = 32,
  parameter int SIZE         = 64,
  parameter int ADDR_W       = 6,
  parameter int ZERO_IDX     = 32,
  parameter int QUIET_CYCLES = 256,
  parameter int MAX_RUN      = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              tstart,
  input  logic              kern_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [WIDTH-1:0]  checksum,
  output logic [31:0]       write_count
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int RW = $clog2(MAX_RUN + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_RUN,
    S_DUMP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         state;
  logic [QW-1:0]  quiet_cnt;
  logic [RW-1:0]  run_cnt;
  logic [WIDTH-1:0] acc;

  function automatic logic [WIDTH-1:0] preload_word(input logic [ADDR_W-1:0] i);
    if (int'(i) == ZERO_IDX) return '0;
    return WIDTH'(i) + WIDTH'(1);
  endfunction

  // Outputs are registered together with the state, so each branch sets the
  // output values belonging to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      tstart      <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      checksum    <= '0;
      write_count <= '0;
      quiet_cnt   <= '0;
      run_cnt     <= '0;
      acc         <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            state       <= S_LOAD;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            checksum    <= '0;
            write_count <= '0;
            acc         <= '0;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= '0;
            mem_wr_data <= preload_word('0);
          end
        end
        S_LOAD: begin
          if (mem_wr_addr == LAST_ADDR) begin
            state       <= S_KICK;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            tstart      <= 1'b1;
          end else begin
            mem_wr_addr <= mem_wr_addr + ADDR_W'(1);
            mem_wr_data <= preload_word(mem_wr_addr + ADDR_W'(1));
          end
        end
        S_KICK: begin
          state     <= S_RUN;
          tstart    <= 1'b0;
          quiet_cnt <= '0;
          run_cnt   <= '0;
        end
        S_RUN: begin
          run_cnt <= run_cnt + RW'(1);
          if (kern_wr_en) begin
            quiet_cnt <= '0;
            if (write_count != '1) write_count <= write_count + 32'd1;
          end else begin
            quiet_cnt <= quiet_cnt + QW'(1);
          end
          // Timeout is tested first so it wins when both exits coincide.
          if (run_cnt == RW'(MAX_RUN - 1)) begin
            timeout     <= 1'b1;
            state       <= S_DUMP;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= '0;
          end else if (!kern_wr_en && quiet_cnt == QW'(QUIET_CYCLES - 1)) begin
            state       <= S_DUMP;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= '0;
          end
        end
        S_DUMP: begin
          // Read data lags the address by one cycle.
          if (mem_rd_addr != '0) acc <= acc + mem_rd_data;
          if (mem_rd_addr == LAST_ADDR) begin
            state       <= S_DRAIN;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
          end else begin
            mem_rd_addr <= mem_rd_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          state    <= S_DONE;
          checksum <= acc + mem_rd_data;
          acc      <= acc + mem_rd_data;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
